serial_to_parallel_framed: RTL

Parametrised successor to the free-running shift-register deserializer. It assembles framed serial bit streams into N-bit words, with:
- qualified input bits (valid strobe plus start-of-frame marker);
- selectable bit order;
- a valid/ready output holding register;
- framing-error and overflow reporting;
- a delivered-word counter.

It sits between a serial link receiver and the TCAM key/data loading path.

---
 rtl/serial_to_parallel_framed.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel_framed.sv
// serial_to_parallel_framed
//   Assembles framed serial bit streams into N-bit words for the TCAM
//   key/data loading path. Input bits are qualified by i_Valid. i_Start
//   marks bit 0 of a frame. Finished words sit in a valid/ready holding
//   register. Frame restarts and dropped words are reported as one-cycle
//   pulses.
//
// Parameters
//   N          word width in bits (2..64)
//   MSB_FIRST  0: first received bit lands in o_Parallel[0]
//              1: first received bit lands in o_Parallel[N-1]
//   CNT_W      width of the delivered-word counter
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_Serial     serial data bit, used only when i_Valid=1
//   i_Valid      qualifies i_Serial this cycle
//   i_Start      marks i_Serial as bit 0 of a new frame (only with i_Valid)
//   i_Ready      downstream accepts o_Parallel this cycle
//   o_Parallel   assembled word, meaningful while o_Valid=1
//   o_Valid      holding register contains an unconsumed word
//   o_Busy       frame assembly in progress
//   o_FrameErr   one-cycle pulse: frame restarted before completion
//   o_Overflow   one-cycle pulse: completed word dropped, holding register full
//   o_WordCount  words loaded into the holding register, wraps
module serial_to_parallel_framed #(
  parameter int N         = 10,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Serial,
  input  logic             i_Valid,
  input  logic             i_Start,
  input  logic             i_Ready,
  output logic [N-1:0]     o_Parallel,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_FrameErr,
  output logic             o_Overflow,
  output logic [CNT_W-1:0] o_WordCount
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [N-1:0]     shift_r, shift_s;
  logic [N-1:0]     word_s;
  logic [N-1:0]     par_s;
  logic             valid_s;
  logic             busy_s;
  logic             ferr_s;
  logic             ovf_s;
  logic [CNT_W-1:0] wc_s;

  // Push one bit into a partial word in the configured direction. After N
  // pushes into an empty word, the first bit sits at [0] (LSB-first) or at
  // [N-1] (MSB-first).
  function automatic logic [N-1:0] insert_bit(input logic [N-1:0] base, input logic b);
    if (MSB_FIRST) begin
      insert_bit = {base[N-2:0], b};
    end else begin
      insert_bit = {b, base[N-1:1]};
    end
  endfunction

  // Next-state, assembly and holding-register logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    par_s   = o_Parallel;
    valid_s = o_Valid;
    ferr_s  = 1'b0;
    ovf_s   = 1'b0;
    wc_s    = o_WordCount;
    word_s  = insert_bit(shift_r, i_Serial);

    // Consumption. A load further down overrides this when both happen on one edge.
    if (o_Valid && i_Ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = o_Valid;
    end

    case (state_r)
      IDLE: begin
        if (i_Valid && i_Start) begin
          state_s = SHIFT;
          cnt_s   = CW'(1);
          shift_s = insert_bit({N{1'b0}}, i_Serial);
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (i_Valid && i_Start) begin
          // A start bit wins over completion, even on the N-th bit.
          ferr_s  = 1'b1;
          cnt_s   = CW'(1);
          shift_s = insert_bit({N{1'b0}}, i_Serial);
        end else if (i_Valid && (cnt_r == CW'(N - 1))) begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
          shift_s = word_s;
          if (!o_Valid || i_Ready) begin
            par_s   = word_s;
            valid_s = 1'b1;
            wc_s    = o_WordCount + CNT_W'(1);
          end else begin
            ovf_s   = 1'b1;
          end
        end else if (i_Valid) begin
          cnt_s   = cnt_r + CW'(1);
          shift_s = word_s;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase

    busy_s = (state_s == SHIFT);
  end

  // State, assembly and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      shift_r     <= {N{1'b0}};
      o_Parallel  <= {N{1'b0}};
      o_Valid     <= 1'b0;
      o_Busy      <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_Overflow  <= 1'b0;
      o_WordCount <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shift_r     <= shift_s;
      o_Parallel  <= par_s;
      o_Valid     <= valid_s;
      o_Busy      <= busy_s;
      o_FrameErr  <= ferr_s;
      o_Overflow  <= ovf_s;
      o_WordCount <= wc_s;
    end
  end

endmodule
